// File: rtl/mtrx_slice_sender.sv
// ============================================================================
// Module   : mtrx_slice_sender
// Brief    : Streams one UNIT_NUM x UNIT_NUM tile from sync-read RAM as
//            valid/ready beats, flagging the last beat with slice_done.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mtrx_slice_sender #(
    parameter int DATA_WIDTH = 16,
    parameter int UNIT_NUM   = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  s_clk,
    input  logic                  s_rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  col_major,
    output logic                  busy,
    output logic                  tile_done,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  slice_valid,
    output logic [DATA_WIDTH-1:0] slice_data,
    output logic                  slice_done,
    input  logic                  slice_ready
);

    localparam int LOG_N = $clog2(UNIT_NUM);
    localparam int IDX_W = 2 * LOG_N + 1;
    localparam int LOG_D = $clog2(FIFO_DEPTH);
    localparam int CNT_W = LOG_D + 1;

    localparam logic [IDX_W-1:0] c_TOTAL = IDX_W'(UNIT_NUM * UNIT_NUM);
    localparam logic [IDX_W-1:0] c_LAST  = IDX_W'(UNIT_NUM * UNIT_NUM - 1);
    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SEND   = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic                  r_col;
    logic [IDX_W-1:0]      r_rd_idx;
    logic [IDX_W-1:0]      r_beat_cnt;
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
    logic                  r_fifo_last [FIFO_DEPTH];
    logic [LOG_D-1:0]      r_wr_ptr;
    logic [LOG_D-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_fifo_cnt;

    logic                  w_start_ok;
    logic                  w_issue;
    logic                  w_hs;
    logic                  w_push;
    logic [CNT_W-1:0]      w_credit;
    logic [2*LOG_N-1:0]    w_idx;
    logic [ADDR_WIDTH-1:0] w_offset;

    assign w_start_ok = start && (r_state == S_IDLE);
    // Reads still travelling through the RAM count against FIFO space.
    assign w_credit   = r_fifo_cnt + CNT_W'(r_inflight);
    assign w_issue    = (r_state == S_SEND) && (r_rd_idx < c_TOTAL) && (w_credit < c_DEPTH);
    assign w_idx      = r_rd_idx[2*LOG_N-1:0];
    // Column-major swaps the row/column fields of the index (N is a power of 2).
    assign w_offset   = r_col ? ADDR_WIDTH'({w_idx[LOG_N-1:0], w_idx[2*LOG_N-1:LOG_N]})
                              : ADDR_WIDTH'(w_idx);

    assign ram_rd_en   = w_issue;
    assign ram_rd_addr = w_issue ? (r_base + w_offset) : '0;

    assign slice_valid = (r_fifo_cnt != '0);
    assign slice_data  = r_fifo_data[r_rd_ptr];
    assign slice_done  = slice_valid && r_fifo_last[r_rd_ptr];
    assign w_hs        = slice_valid && slice_ready;
    assign w_push      = r_inflight;

    assign busy      = (r_state == S_SEND);
    assign tile_done = (r_state == S_FINISH);

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (w_start_ok) r_state <= S_SEND;
                S_SEND:   if (w_hs && (r_beat_cnt == c_LAST)) r_state <= S_FINISH;
                S_FINISH: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            r_base          <= '0;
            r_col           <= 1'b0;
            r_rd_idx        <= '0;
            r_beat_cnt      <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_base     <= base_addr;
                r_col      <= col_major;
                r_rd_idx   <= '0;
                r_beat_cnt <= '0;
            end else begin
                if (w_issue) r_rd_idx   <= r_rd_idx + IDX_W'(1);
                if (w_hs)    r_beat_cnt <= r_beat_cnt + IDX_W'(1);
            end
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_rd_idx == c_LAST);
        end
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_last[i] <= 1'b0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= ram_rd_data;
                r_fifo_last[r_wr_ptr] <= r_inflight_last;
                r_wr_ptr              <= r_wr_ptr + LOG_D'(1);
            end
            if (w_hs) r_rd_ptr <= r_rd_ptr + LOG_D'(1);
            case ({w_push, w_hs})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    a_done_consistent: assert property (@(posedge s_clk) disable iff (s_rst)
        w_hs |-> (slice_done == (r_beat_cnt == c_LAST)));

endmodule

`default_nettype wire

// File: tb/tb_mtrx_slice_sender.sv
// ============================================================================
// Module   : tb_mtrx_slice_sender
// Brief    : Randomized self-checking bench for mtrx_slice_sender (N=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mtrx_slice_sender;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 12;
    localparam int FD = 4;

    logic          s_clk = 1'b0;
    logic          s_rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          col_major;
    logic          busy;
    logic          tile_done;
    logic          ram_rd_en;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;
    logic          slice_valid;
    logic [DW-1:0] slice_data;
    logic          slice_done;
    logic          slice_ready;

    mtrx_slice_sender #(
        .DATA_WIDTH(DW), .UNIT_NUM(N), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)
    ) dut (
        .s_clk(s_clk), .s_rst(s_rst), .start(start), .base_addr(base_addr),
        .col_major(col_major), .busy(busy), .tile_done(tile_done),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .slice_valid(slice_valid), .slice_data(slice_data), .slice_done(slice_done),
        .slice_ready(slice_ready)
    );

    always #5 s_clk = ~s_clk;

    // RAM holds word[a] = a.
    always @(posedge s_clk) if (ram_rd_en) ram_rd_data <= DW'(ram_rd_addr);

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] tile_addr(input logic [AW-1:0] b, input logic c, input int i);
        int off;
        off = c ? ((i % N) * N + (i / N)) : i;
        return AW'(int'(b) + off);
    endfunction

    // Reference model state
    logic          m_busy, m_tdone;
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] addr_q[$];
    logic [DW-1:0] obs_q[$];
    int            m_issued, m_popped, n_tdone;
    logic          prev_valid, prev_ready;
    logic [DW-1:0] prev_data;

    initial begin
        m_busy = 0; m_tdone = 0; m_issued = 0; m_popped = 0; n_tdone = 0;
        prev_valid = 0; prev_ready = 0; prev_data = '0;
    end

    always @(negedge s_clk) begin : cmp
        logic fin, acc;
        if (s_rst) begin
            chk("rst_valid", slice_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_rd_en", ram_rd_en, 0);
            chk("rst_tile_done", tile_done, 0);
            chk("rst_done", slice_done, 0);
            chk("rst_rd_addr", ram_rd_addr, 0);
            chk("rst_data", slice_data, 0);
            exp_q.delete(); addr_q.delete();
            m_busy = 0; m_tdone = 0; prev_valid = 0; m_issued = 0; m_popped = 0;
        end else begin
            chk("busy", busy, m_busy);
            chk("tile_done", tile_done, m_tdone);
            if (tile_done) begin
                n_tdone++;
                chk("tile_leftover", exp_q.size() + addr_q.size(), 0);
            end
            if (ram_rd_en) begin
                if (addr_q.size() == 0) chk("rd_unexpected", 1, 0);
                else begin
                    chk("rd_addr", ram_rd_addr, addr_q[0]);
                    void'(addr_q.pop_front());
                end
                chk("credit", (m_issued - m_popped) < FD, 1);
                m_issued++;
            end
            if (prev_valid && !prev_ready) begin
                chk("hold_valid", slice_valid, 1);
                chk("hold_data", slice_data, prev_data);
            end
            fin = 0;
            if (slice_valid) begin
                if (exp_q.size() == 0) chk("valid_unexpected", 1, 0);
                else begin
                    chk("beat_data", slice_data, exp_q[0]);
                    chk("beat_done", slice_done, exp_q.size() == 1);
                    if (slice_ready) begin
                        fin = (exp_q.size() == 1);
                        obs_q.push_back(slice_data);
                        void'(exp_q.pop_front());
                        m_popped++;
                    end
                end
            end else begin
                chk("done_without_valid", slice_done, 0);
            end
            acc = start && !m_busy && !m_tdone;
            m_tdone = fin;
            if (acc) begin
                m_busy = 1; m_issued = 0; m_popped = 0;
                exp_q.delete(); addr_q.delete(); obs_q.delete();
                for (int i = 0; i < N * N; i++) begin
                    addr_q.push_back(tile_addr(base_addr, col_major, i));
                    exp_q.push_back(DW'(tile_addr(base_addr, col_major, i)));
                end
            end else if (fin) begin
                m_busy = 0;
            end
            prev_valid = slice_valid; prev_ready = slice_ready; prev_data = slice_data;
        end
    end

    // Ready pattern: 0 = always 1, 1 = 1,0,0,1 repeating, 2 = random
    int rdy_mode = 0;
    initial begin
        int ph;
        ph = 0;
        slice_ready = 1'b1;
        forever begin
            @(posedge s_clk); #1;
            case (rdy_mode)
                1:       slice_ready = (ph % 4 == 0) || (ph % 4 == 3);
                2:       slice_ready = 1'($urandom_range(0, 1));
                default: slice_ready = 1'b1;
            endcase
            ph++;
        end
    end

    task automatic go(input logic [AW-1:0] b, input logic c);
        @(posedge s_clk); #1;
        base_addr = b; col_major = c; start = 1'b1;
        @(posedge s_clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_tdone(input string nm, input int budget);
        logic found;
        found = 0;
        for (int i = 0; i < budget; i++) begin
            if (tile_done) begin found = 1; break; end
            @(posedge s_clk); #1;
        end
        chk(nm, found, 1);
        @(posedge s_clk); #1;
    endtask

    task automatic wait_beats(input int n, input int budget);
        logic found;
        found = 0;
        for (int i = 0; i < budget; i++) begin
            if (obs_q.size() >= n) begin found = 1; break; end
            @(posedge s_clk); #1;
        end
        chk("wait_beats", found, 1);
    endtask

    initial begin
        int first, td, base_td;
        logic found;
        start = 0; base_addr = '0; col_major = 0; s_rst = 1'b0;
        #1 s_rst = 1'b1;
        repeat (3) @(posedge s_clk);
        #1 s_rst = 1'b0;
        @(posedge s_clk); #1;

        // Row-major, ready high: latency and throughput pinned literally
        base_addr = 12'h010; col_major = 0; start = 1'b1;
        first = -1; td = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge s_clk); #1;
            start = 1'b0;
            if (slice_valid && first < 0) first = n;
            if (tile_done) begin td = n; break; end
        end
        chk("first_valid_cycle", first, 3);
        chk("tile_done_cycle", td, 19);
        chk("t1_count", obs_q.size(), 16);
        chk("t1_first", obs_q[0], 16'h0010);
        chk("t1_last", obs_q[15], 16'h001F);

        // Column-major
        go(12'h100, 1'b1);
        wait_tdone("t2_timeout", 60);
        chk("t2_beat1", obs_q[1], 16'h0104);
        chk("t2_beat4", obs_q[4], 16'h0101);
        chk("t2_last", obs_q[15], 16'h010F);

        // Backpressure 1,0,0,1
        rdy_mode = 1;
        go(12'h000, 1'b0);
        wait_tdone("t3_timeout", 200);
        chk("t3_count", obs_q.size(), 16);
        chk("t3_last", obs_q[15], 16'h000F);
        rdy_mode = 0;

        // Start pulsed mid-transfer is ignored
        base_td = n_tdone;
        go(12'h050, 1'b0);
        wait_beats(5, 50);
        base_addr = 12'h700; start = 1'b1;
        @(posedge s_clk); #1;
        start = 1'b0;
        wait_tdone("t4_timeout", 60);
        repeat (3) @(posedge s_clk);
        #1;
        chk("t4_tdone_count", n_tdone - base_td, 1);
        chk("t4_count", obs_q.size(), 16);
        chk("t4_last", obs_q[15], 16'h005F);

        // Fresh tile; start coincident with tile_done is dropped
        go(12'h020, 1'b0);
        found = 0;
        for (int i = 0; i < 60; i++) begin
            if (slice_valid && slice_ready && slice_done) begin found = 1; break; end
            @(posedge s_clk); #1;
        end
        chk("t5_last_beat_seen", found, 1);
        @(posedge s_clk); #1;
        chk("t5_tile_done", tile_done, 1);
        base_addr = 12'h300; start = 1'b1;
        @(posedge s_clk); #1;
        start = 1'b0;
        repeat (3) @(posedge s_clk);
        #1;
        chk("t5_start_dropped", busy, 0);
        chk("t5_first", obs_q[0], 16'h0020);
        chk("t5_last", obs_q[15], 16'h002F);

        // Address wrap
        go(12'hFFC, 1'b0);
        wait_tdone("t6_timeout", 60);
        chk("t6_pre_wrap", obs_q[3], 16'h0FFF);
        chk("t6_wrap", obs_q[4], 16'h0000);
        chk("t6_last", obs_q[15], 16'h000B);

        // Random tiles with random backpressure
        rdy_mode = 2;
        for (int t = 0; t < 6; t++) begin
            go(AW'($urandom), 1'($urandom_range(0, 1)));
            wait_tdone("rand_timeout", 400);
            chk("rand_count", obs_q.size(), 16);
        end
        rdy_mode = 0;

        // Reset mid-tile
        go(12'h0A0, 1'b0);
        wait_beats(7, 50);
        s_rst = 1'b1;
        #1;
        chk("midrst_valid", slice_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_rd_en", ram_rd_en, 0);
        repeat (2) @(posedge s_clk);
        #1 s_rst = 1'b0;
        go(12'h030, 1'b0);
        wait_tdone("t7_timeout", 60);
        chk("t7_count", obs_q.size(), 16);
        chk("t7_first", obs_q[0], 16'h0030);
        chk("t7_last", obs_q[15], 16'h003F);

        repeat (4) @(posedge s_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
